vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 Parameter TICK_DIV, default 4, system clocks per pixel (100 MHz to 25 MHz).
REQ-010 Port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-011 Port reset, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-012 Port p_tick, output, 1, one-clk pixel-enable pulse, once every TICK_DIV clks.
REQ-013 Port x, output, 10, current horizontal pixel count, fed to glyph and sprite modules.
REQ-014 Port y, output, 10, current vertical line count, fed to glyph and sprite modules.
REQ-015 Port hsync, output, 1, horizontal sync, active low, registered.
REQ-016 Port vsync, output, 1, vertical sync, active low, registered.
REQ-017 Port video_on, output, 1, high while x < H_DISPLAY and y < V_DISPLAY.
REQ-018 Port frame_end, output, 1, one-clk pulse on the last pixel of each frame, for game-logic update.

Function
REQ-019 Divider counter counts 0..TICK_DIV-1 every clk and wraps to 0; p_tick is high exactly when the divider equals TICK_DIV-1.
REQ-020 x and y change only on a clk edge where p_tick is high; at all other edges they hold.
REQ-021 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525).
REQ-022 On a p_tick edge: if x = H_TOTAL-1, x wraps to 0; otherwise x increments by 1.
REQ-023 On a p_tick edge with x = H_TOTAL-1: if y = V_TOTAL-1, y wraps to 0; otherwise y increments by 1. Otherwise y holds.
REQ-024 x never exceeds H_TOTAL-1 and y never exceeds V_TOTAL-1; no other wrap or saturation exists.
REQ-025 hsync is registered from the next-x value, so it is aligned with x: low iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (default 656..751).
REQ-026 vsync is registered from the next-y value, so it is aligned with y: low iff V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (default 490..491).
REQ-027 video_on is a combinational decode of the registered x and y, with zero latency relative to them.
REQ-028 frame_end is high for exactly one clk, namely the clk where p_tick is high, x = H_TOTAL-1 and y = V_TOTAL-1.
REQ-029 Downstream glyph and sprite logic sees x, y, video_on, hsync and vsync mutually consistent in every clk cycle.

Reset
REQ-030 reset is synchronous and active-high: while it is sampled high, the divider = 0, x = 0, y = 0, hsync = 1, vsync = 1, p_tick = 0 and frame_end = 0.
REQ-031 Because video_on is decoded, video_on = 1 during reset, since (0,0) is visible.
REQ-032 reset asserted mid-line or mid-frame takes priority over counting; on release, the first p_tick occurs TICK_DIV clks later and x steps from 0 to 1.
REQ-033 There are no initial-value dependencies; all state is defined only through reset.

Verification
REQ-034 Assert reset for 3 clks, then release -> p_tick is high on clks 4, 8, 12, ... after release; x = 1 after the first p_tick; y = 0.
REQ-035 Run one full line -> x sequence 0..799 then 0; y goes from 0 to 1 at the x = 799 wrap; hsync is low for exactly 96 p_ticks starting at x = 656.
REQ-036 Run one full frame -> vsync is low exactly while y = 490..491 (1600 p_ticks); video_on is high for exactly 640*480 = 307200 p_ticks.
REQ-037 Frame boundary -> frame_end pulses once per 420000 p_ticks (800*525), only at x = 799, y = 524, and the next p_tick gives x = 0, y = 0.
REQ-038 Assert reset at x = 700, y = 491, while hsync and vsync are low -> next clk x = 0, y = 0, hsync = 1, vsync = 1, p_tick = 0.
REQ-039 Check continuously -> video_on = 0 whenever hsync = 0 or vsync = 0; x < 800 and y < 525 always.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-tick divider plus x/y raster counters with registered,
// active-low hsync/vsync aligned to x/y and decoded video_on/frame_end.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int TICK_DIV  = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_end
);
    localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          h_wrap;

    always_comb begin
        p_tick  = div_q == DIV_LAST;
        h_wrap  = p_tick && x_q == H_LAST;
        div_d   = p_tick ? '0 : div_q + DW'(1);
        x_d     = !p_tick ? x_q : (h_wrap ? 10'd0 : x_q + 10'd1);
        y_d     = !h_wrap ? y_q : (y_q == V_LAST ? 10'd0 : y_q + 10'd1);
        // Syncs are decoded from the next counter values so that, once
        // registered, they line up with x/y in the same cycle.
        hsync_d = !(x_d >= HS_START && x_d < HS_END);
        vsync_d = !(y_d >= VS_START && y_d < VS_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = x_q < H_VIS && y_q < V_VIS;
    assign frame_end = h_wrap && y_q == V_LAST;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized-reset scoreboard bench; the reference derives
// every output from the count of clocks since the last reset.
module tb_vga_sync_gen;
    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6, VF = 1, VS = 2, VB = 2;
    localparam int TD = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * TD;

    typedef struct packed {
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_tick, hsync, vsync, video_on, frame_end;
    logic [9:0] x, y;

    exp_t   q[$];
    int     tests = 0;
    int     fails = 0;
    longint k = 0;
    int     exp_frames = 0;
    int     dut_frames = 0;
    int     von_cnt = 0, hs_cnt = 0, vs_cnt = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_end(frame_end)
    );

    // n clocks since reset release: n/TD pixels done, raster position by div/mod.
    function automatic exp_t model(longint n);
        exp_t   e;
        longint t = n / TD;
        int     xx = int'(t % HT);
        int     yy = int'((t / HT) % VT);
        e.pt  = (n % TD) == TD - 1;
        e.x   = 10'(xx);
        e.y   = 10'(yy);
        e.hs  = !(xx >= HD + HF && xx < HD + HF + HS);
        e.vs  = !(yy >= VD + VF && yy < VD + VF + VS);
        e.von = xx < HD && yy < VD;
        e.fe  = e.pt && xx == HT - 1 && yy == VT - 1;
        return e;
    endfunction

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(bit r);
        exp_t e;
        reset = r;
        @(posedge clk);
        k = r ? 0 : k + 1;
        e = model(k);
        if (e.fe) exp_frames++;
        q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("p_tick", int'(p_tick), int'(e.pt));
            check("x", int'(x), int'(e.x));
            check("y", int'(y), int'(e.y));
            check("hsync", int'(hsync), int'(e.hs));
            check("vsync", int'(vsync), int'(e.vs));
            check("video_on", int'(video_on), int'(e.von));
            check("frame_end", int'(frame_end), int'(e.fe));
            check("von_in_sync", int'(video_on && !(hsync && vsync)), 0);
            check("x_range", int'(x < 10'(HT)), 1);
            check("y_range", int'(y < 10'(VT)), 1);
            if (reset) begin
                von_cnt = 0; hs_cnt = 0; vs_cnt = 0;
            end else if (p_tick) begin
                von_cnt += int'(video_on);
                hs_cnt  += int'(!hsync);
                vs_cnt  += int'(!vsync);
                if (frame_end) begin
                    dut_frames++;
                    check("frame_video_ticks", von_cnt, HD * VD);
                    check("frame_hsync_ticks", hs_cnt, HS * VT);
                    check("frame_vsync_ticks", vs_cnt, VS * HT);
                    von_cnt = 0; hs_cnt = 0; vs_cnt = 0;
                end
            end
        end
    end

    initial begin
        exp_t m;
        repeat (3) step(1'b1);
        for (int i = 0; i < 3 * FRAME_CLKS + 20; i++)
            step($urandom_range(0, 999) == 0);
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            m = model(k);
            if (!m.hs && !m.vs) break;
            step(1'b0);
        end
        step(1'b1);
        for (int i = 0; i < FRAME_CLKS + 2 * TD; i++)
            step($urandom_range(0, 1999) == 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        check("frame_count", dut_frames, exp_frames);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
